// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared FSM encodings and helpers for the bit-serial arithmetic blocks
package arith_pkg;

  localparam logic IDLE  = 1'b0;
  localparam logic SHIFT = 1'b1;

  // Bits needed to count 0 .. value-1; never less than one bit.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    if (r == 0) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - one-bit gate-level full subtractor cell
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic Diff,
  output logic Bout
);

  logic a_xor_b;

  assign a_xor_b = A ^ B;
  assign Diff    = a_xor_b ^ Bin;
  assign Bout    = (~A & B) | (~a_xor_b & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b - bin, LSB first, one bit per clock
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             overflow
);

  localparam int            CW   = clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic             cell_diff;
  logic             cell_bout;

  full_subtractor u_cell (
    .A    (a_sr_q[0]),
    .B    (b_sr_q[0]),
    .Bin  (brw_q),
    .Diff (cell_diff),
    .Bout (cell_bout)
  );

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    brw_d   = brw_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;

    if (state_q == IDLE) begin
      if (start) begin
        a_sr_d  = a;
        b_sr_d  = b;
        brw_d   = bin;
        res_d   = '0;
        cnt_d   = '0;
        busy_d  = 1'b1;
        state_d = SHIFT;
      end
    end else begin
      res_d  = {cell_diff, res_q[WIDTH-1:1]};
      a_sr_d = a_sr_q >> 1;
      b_sr_d = b_sr_q >> 1;
      brw_d  = cell_bout;
      cnt_d  = cnt_q + CW'(1);
      if (cnt_q == LAST) begin
        // brw_q here is the borrow into the sign-bit cell
        diff_d  = {cell_diff, res_q[WIDTH-1:1]};
        bout_d  = cell_bout;
        ovf_d   = brw_q ^ cell_bout;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign diff     = diff_q;
  assign bout     = bout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         overflow;

  int n_vec    = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .bout     (bout),
    .overflow (overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_diff(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    longint r;
    r = longint'(x) - longint'(y) - longint'(c);
    return W'(r);
  endfunction

  function automatic logic ref_bout(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return longint'(x) < (longint'(y) + longint'(c));
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    longint r;
    longint lim;
    r   = longint'($signed(x)) - longint'($signed(y)) - longint'(c);
    lim = longint'(1) << (W - 1);
    return (r < -lim) || (r > lim - 1);
  endfunction

  // Reference: an accepted request completes W edges later with the arithmetic result.
  logic         m_busy, m_done, m_bout, m_ovf, p_bout, p_ovf;
  logic [W-1:0] m_diff, p_diff;
  int           m_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_diff <= '0;
      m_bout <= 1'b0;
      m_ovf  <= 1'b0;
      m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_diff <= p_diff;
          m_bout <= p_bout;
          m_ovf  <= p_ovf;
        end
      end else if (start) begin
        m_left <= W;
        m_busy <= 1'b1;
        p_diff <= ref_diff(a, b, bin);
        p_bout <= ref_bout(a, b, bin);
        p_ovf  <= ref_ovf(a, b, bin);
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    chk("diff", 32'(diff), 32'(m_diff));
    chk("bout", 32'(bout), 32'(m_bout));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (done === 1'b1) begin
      done_cnt++;
    end
  end

  // Called at the first falling edge after the accepting edge; returns edges elapsed after it.
  task automatic wait_done(output int edges);
    int n;
    n = 1;
    while (done !== 1'b1 && n < 4 * W) begin
      @(negedge clk);
      n++;
    end
    edges = n - 1;
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                        input logic [W-1:0] ed, input logic eb, input logic eo, input string nm);
    int d0;
    int lat;
    d0    = done_cnt;
    a     = x;
    b     = y;
    bin   = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    bin   = 1'($urandom);
    wait_done(lat);
    chk({nm, "_latency"}, 32'(lat), 32'(W));
    chk({nm, "_diff"}, 32'(diff), 32'(ed));
    chk({nm, "_bout"}, 32'(bout), 32'(eb));
    chk({nm, "_ovf"}, 32'(overflow), 32'(eo));
    @(negedge clk);
    chk({nm, "_done_width"}, 32'(done), 32'd0);
    chk({nm, "_done_count"}, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int d0;
    int lat;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_diff", 32'(diff), 32'd0);
    chk("reset_bout", 32'(bout), 32'd0);
    chk("reset_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(8'd5, 8'd3, 1'b0, 8'h02, 1'b0, 1'b0, "unsigned");
    run_op(8'd3, 8'd5, 1'b0, 8'hFE, 1'b1, 1'b0, "borrow_out");

    // Abort mid-operation with outputs still holding the previous nonzero result.
    a     = 8'd200;
    b     = 8'd1;
    bin   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_diff", 32'(diff), 32'd0);
    chk("abort_bout", 32'(bout), 32'd0);
    chk("abort_ovf", 32'(overflow), 32'd0);
    d0 = done_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    chk("abort_idle", 32'(busy), 32'd0);
    run_op(8'd10, 8'd10, 1'b0, 8'h00, 1'b0, 1'b0, "post_reset");

    run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, "signed_ovf");
    run_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, "borrow_in");
    run_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, "neg_ovf");

    // A second start while busy must not disturb the captured operands.
    d0    = done_cnt;
    a     = 8'd9;
    b     = 8'd4;
    bin   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    a     = 8'd1;
    b     = 8'd1;
    @(negedge clk);
    start = 1'b0;
    a     = 8'd0;
    b     = 8'd0;
    wait_done(lat);
    chk("busy_start_diff", 32'(diff), 32'h05);
    @(negedge clk);
    chk("busy_start_one_done", 32'(done_cnt - d0), 32'd1);

    // Start held through done: the next operation is accepted on the done cycle.
    a     = 8'd9;
    b     = 8'd4;
    start = 1'b1;
    @(negedge clk);
    a     = 8'd1;
    b     = 8'd1;
    wait_done(lat);
    chk("held_first_diff", 32'(diff), 32'h05);
    @(negedge clk);
    start = 1'b0;
    chk("held_second_busy", 32'(busy), 32'd1);
    wait_done(lat);
    chk("held_second_latency", 32'(lat), 32'(W));
    chk("held_second_diff", 32'(diff), 32'h00);
    chk("held_second_bout", 32'(bout), 32'd0);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
